// File: rtl/flight_sequencer.sv
// Launch/ascent phase controller: sequences ignition, integration, pitch-over,
// burnout, coast and done, and keeps the mission clock in whole seconds.
module flight_sequencer #(
    parameter int unsigned     N             = 64,
    parameter int unsigned     TICKS_PER_SEC = 50_000,
    parameter int unsigned     HOLD_TICKS    = 10,
    parameter longint unsigned GIMBAL_HEIGHT = 64'd30_000_000,
    parameter int unsigned     COAST_S       = 20
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         launch,
    input  logic         abort,
    input  logic [31:0]  burntime,
    input  logic [N-1:0] height,
    output logic         engine_on,
    output logic         start_integration,
    output logic         gimbal_enable,
    output logic [2:0]   phase,
    output logic [31:0]  elapsed_s,
    output logic         done,
    output logic         aborted
);

    localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int unsigned SEC_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IGNITE = 3'd1,
        S_ASCENT = 3'd2,
        S_PITCH  = 3'd3,
        S_COAST  = 3'd4,
        S_DONE   = 3'd5,
        S_ABORT  = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [SEC_W-1:0]   elapsed_q, elapsed_d;
    logic [SEC_W-1:0]   burn_q, burn_d;
    logic               engine_on_q, engine_on_d;
    logic               start_integration_q, start_integration_d;
    logic               gimbal_enable_q, gimbal_enable_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic               running;
    logic               burnout;
    logic               coast_end;
    logic               at_height;

    // Next-state, mission clock and Moore output decode of the next state.
    always_comb begin
        state_d             = state_q;
        tick_d              = tick_q;
        hold_d              = hold_q;
        elapsed_d           = elapsed_q;
        burn_d              = burn_q;
        engine_on_d         = 1'b0;
        start_integration_d = 1'b0;
        gimbal_enable_d     = 1'b0;
        done_d              = 1'b0;
        aborted_d           = 1'b0;

        running = (state_q == S_ASCENT) || (state_q == S_PITCH) || (state_q == S_COAST);
        if (running) begin
            if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
                tick_d = '0;
                if (elapsed_q != '1) begin
                    elapsed_d = elapsed_q + 32'd1;
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        // Transitions look at the post-increment second count.
        burnout   = (elapsed_d == burn_q);
        coast_end = ({1'b0, elapsed_d} == ({1'b0, burn_q} + 33'(COAST_S)));
        at_height = (height >= N'(GIMBAL_HEIGHT));

        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d   = S_IGNITE;
                    burn_d    = burntime;
                    hold_d    = '0;
                    tick_d    = '0;
                    elapsed_d = '0;
                end
            end
            S_IGNITE: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                    state_d = (burn_q == '0) ? S_COAST : S_ASCENT;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_ASCENT: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (burnout) begin
                    state_d = S_COAST;
                end else if (at_height) begin
                    state_d = S_PITCH;
                end
            end
            S_PITCH: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (burnout) begin
                    state_d = S_COAST;
                end
            end
            S_COAST: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (coast_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ABORT: state_d = S_ABORT;
            default: state_d = S_IDLE;
        endcase

        engine_on_d         = (state_d == S_IGNITE) || (state_d == S_ASCENT) || (state_d == S_PITCH);
        start_integration_d = (state_d == S_ASCENT) || (state_d == S_PITCH) || (state_d == S_COAST);
        gimbal_enable_d     = (state_d == S_PITCH);
        done_d              = (state_d == S_DONE);
        aborted_d           = (state_d == S_ABORT);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q             <= S_IDLE;
            tick_q              <= '0;
            hold_q              <= '0;
            elapsed_q           <= '0;
            burn_q              <= '0;
            engine_on_q         <= 1'b0;
            start_integration_q <= 1'b0;
            gimbal_enable_q     <= 1'b0;
            done_q              <= 1'b0;
            aborted_q           <= 1'b0;
        end else begin
            state_q             <= state_d;
            tick_q              <= tick_d;
            hold_q              <= hold_d;
            elapsed_q           <= elapsed_d;
            burn_q              <= burn_d;
            engine_on_q         <= engine_on_d;
            start_integration_q <= start_integration_d;
            gimbal_enable_q     <= gimbal_enable_d;
            done_q              <= done_d;
            aborted_q           <= aborted_d;
        end
    end

    assign phase             = state_q;
    assign elapsed_s         = elapsed_q;
    assign engine_on         = engine_on_q;
    assign start_integration = start_integration_q;
    assign gimbal_enable     = gimbal_enable_q;
    assign done              = done_q;
    assign aborted           = aborted_q;

endmodule

// File: tb/tb_flight_sequencer.sv
// Scoreboard bench for flight_sequencer: a mission-level model predicts every
// cycle's outputs; a monitor compares them on the falling edge.
module tb_flight_sequencer;

    localparam int unsigned     N     = 64;
    localparam int unsigned     TPS   = 4;
    localparam int unsigned     HOLD  = 2;
    localparam int unsigned     COAST = 2;
    localparam longint unsigned GH    = 64'd30_000_000;

    typedef struct packed {
        logic [2:0]  phase;
        logic        eng;
        logic        integ;
        logic        gimb;
        logic [31:0] el;
        logic        done;
        logic        ab;
    } obs_t;

    logic         clk = 1'b0;
    logic         resetb;
    logic         launch;
    logic         abort;
    logic [31:0]  burntime;
    logic [N-1:0] height;
    logic         engine_on, start_integration, gimbal_enable, done, aborted;
    logic [2:0]   phase;
    logic [31:0]  elapsed_s;

    int vectors = 0;
    int miscompares = 0;
    obs_t exp_q[$];

    // Mission model: phase name plus total integration ticks since ASCENT/COAST start.
    int      m_ph;
    int      m_hold;
    longint  m_ticks;
    longint  m_bt;

    flight_sequencer #(
        .N(N), .TICKS_PER_SEC(TPS), .HOLD_TICKS(HOLD),
        .GIMBAL_HEIGHT(GH), .COAST_S(COAST)
    ) dut (
        .clk(clk), .resetb(resetb), .launch(launch), .abort(abort),
        .burntime(burntime), .height(height),
        .engine_on(engine_on), .start_integration(start_integration),
        .gimbal_enable(gimbal_enable), .phase(phase), .elapsed_s(elapsed_s),
        .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_obs();
        obs_t o;
        longint secs;
        secs = m_ticks / TPS;
        if (secs > 64'hFFFF_FFFF) secs = 64'hFFFF_FFFF;
        o.phase = 3'(m_ph);
        o.eng   = (m_ph == 1) || (m_ph == 2) || (m_ph == 3);
        o.integ = (m_ph == 2) || (m_ph == 3) || (m_ph == 4);
        o.gimb  = (m_ph == 3);
        o.el    = 32'(secs);
        o.done  = (m_ph == 5);
        o.ab    = (m_ph == 6);
        return o;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_hold = 0; m_ticks = 0; m_bt = 0;
    endtask

    task automatic model_step(input logic l, input logic a, input logic [31:0] bt, input logic [N-1:0] h);
        longint nt;
        longint nsec;
        bit     run;
        run  = (m_ph >= 2) && (m_ph <= 4);
        nt   = run ? m_ticks + 1 : m_ticks;
        nsec = nt / TPS;
        case (m_ph)
            0: if (l) begin m_ph = 1; m_bt = longint'(bt); m_hold = 0; nt = 0; end
            1: if (a) m_ph = 6;
               else if (m_hold == HOLD - 1) m_ph = (m_bt == 0) ? 4 : 2;
               else m_hold++;
            2: if (a) m_ph = 6;
               else if (nsec == m_bt) m_ph = 4;
               else if (h >= N'(GH)) m_ph = 3;
            3: if (a) m_ph = 6;
               else if (nsec == m_bt) m_ph = 4;
            4: if (a) m_ph = 6;
               else if (nsec == m_bt + COAST) m_ph = 5;
            default: ;
        endcase
        m_ticks = nt;
    endtask

    // Inputs are held across a rising edge; the model sees the same values the DUT sampled.
    task automatic cycle(input logic l, input logic a, input logic [31:0] bt, input logic [N-1:0] h);
        launch = l; abort = a; burntime = bt; height = h;
        @(posedge clk);
        if (!resetb) model_reset();
        else model_step(l, a, bt, h);
        exp_q.push_back(model_obs());
        #1;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(model_obs());
        repeat (2) cycle(1'b0, 1'b0, 32'd0, '0);
        resetb = 1'b1;
    endtask

    // Monitor: one comparison per cycle the driver has predicted.
    initial begin
        obs_t e, act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = '{phase: phase, eng: engine_on, integ: start_integration, gimb: gimbal_enable,
                        el: elapsed_s, done: done, ab: aborted};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t got ph=%0d eng=%b int=%b gim=%b el=%0d done=%b ab=%b exp ph=%0d eng=%b int=%b gim=%b el=%0d done=%b ab=%b",
                             vectors, $time, act.phase, act.eng, act.integ, act.gimb, act.el, act.done, act.ab,
                             e.phase, e.eng, e.integ, e.gimb, e.el, e.done, e.ab);
                end
            end
        end
    end

    initial begin
        logic [31:0]  bt;
        logic [N-1:0] h;
        int           len;
        resetb = 1'b0; launch = 1'b0; abort = 1'b0; burntime = '0; height = '0;
        model_reset();
        #1;
        repeat (3) cycle(1'b0, 1'b0, 32'd0, '0);
        resetb = 1'b1;

        // Abort and launch held while in reset's IDLE are both ignored except launch.
        repeat (3) cycle(1'b0, 1'b1, 32'd3, '0);

        // Nominal flight.
        cycle(1'b1, 1'b0, 32'd3, '0);
        repeat (40) cycle(1'b0, 1'b0, 32'd7, '0);

        // Gimbal threshold crossed mid-ascent.
        do_reset();
        cycle(1'b1, 1'b0, 32'd3, '0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 32'd3, (i >= 6) ? N'(GH) : N'(GH - 1));

        // Threshold reached on the burnout edge.
        do_reset();
        cycle(1'b1, 1'b0, 32'd2, '0);
        for (int i = 0; i < 30; i++) begin
            h = (m_ph == 2 && m_ticks + 1 == m_bt * TPS) ? N'(GH) : '0;
            cycle(1'b0, 1'b0, 32'd2, h);
        end

        // Abort in PITCH, then pokes that must be ignored.
        do_reset();
        cycle(1'b1, 1'b0, 32'd4, N'(GH));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd4, N'(GH));
        cycle(1'b0, 1'b1, 32'd4, N'(GH));
        for (int i = 0; i < 6; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'd1, '0);

        // Zero burntime goes straight to coast; launch pulses later are ignored.
        do_reset();
        cycle(1'b1, 1'b0, 32'd0, '0);
        for (int i = 0; i < 16; i++) cycle(1'(i % 2), 1'b0, 32'd5, '0);
        do_reset();
        cycle(1'b1, 1'b0, 32'd2, '0);
        for (int i = 0; i < 30; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 32'd1, '0);

        // Randomised missions.
        for (int s = 0; s < 30; s++) begin
            do_reset();
            bt  = 32'($urandom_range(0, 4));
            len = (int'(bt) + COAST + 2) * TPS + 8;
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'($urandom_range(0, 1)), bt, '0);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) h = {$urandom, $urandom};
                else h = N'($urandom_range(0, 32'd29_999_999));
                cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 80) == 0),
                      32'($urandom_range(0, 9)), h);
            end
            if (s == 0) bt = 32'd0;
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
